// File: rtl/mcif_rd_nr_pkg.sv
// Shared AXI read-side constants and request payload helpers for the MCIF read front-end.
// The read and write front-ends both import this package, so the AXI attribute values are defined only once.
package mcif_rd_nr_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [3:0] AXI_CACHE_MOD  = 4'b0010;
    localparam logic [2:0] AXI_PROT_DFLT  = 3'b000;
    localparam logic [3:0] AXI_QOS_DFLT   = 4'b0000;

    // ARSIZE encodes bytes-per-beat as log2, so a full-width beat is log2(DATA_W/8).
    function automatic logic [2:0] axi_size(input int data_w);
        return 3'($clog2(data_w / 8));
    endfunction

    // Base bit of client i's {len,addr} payload; addr sits at the bottom, len above it.
    function automatic int req_pd_base(input int client, input int addr_w, input int len_w);
        return client * (addr_w + len_w);
    endfunction

endpackage

// File: rtl/mcif_rr_arb.sv
// Round-robin arbiter with a one-hot grant and a pointer that moves just past the last winner.
// It is kept generic so that the write-side front-end can reuse it.
module mcif_rr_arb #(
    parameter int N = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         en,
    output logic [N-1:0] grant
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] winner;
    logic          found;
    int            idx;

    always_comb begin
        grant  = '0;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int off = 0; off < N; off++) begin
            idx = (int'(ptr) + off) % N;
            if (en && !found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                winner     = PW'(idx);
            end
        end
    end

    // A grant is always taken, because the client's ready is the grant itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (found) begin
            ptr <= (winner == PW'(N - 1)) ? '0 : winner + 1'b1;
        end
    end

endmodule

// File: rtl/mcif_rd_nr.sv
// N-client AXI4 read front-end: arbitrates client requests onto one AR channel (ARID = client index),
// steers R beats back by RID, and uses per-client beat credits to keep the client response FIFOs from overflowing.
module mcif_rd_nr
    import mcif_rd_nr_pkg::*;
#(
    parameter int NUM_RD   = 5,
    parameter int ID_WIDTH = 3,
    parameter int ADDR_W   = 32,
    parameter int LEN_W    = 8,
    parameter int DATA_W   = 256,
    parameter int CREDIT   = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_RD-1:0]                rd_req_vld,
    output logic [NUM_RD-1:0]                rd_req_rdy,
    input  logic [NUM_RD*(LEN_W+ADDR_W)-1:0] rd_req_pd,
    output logic [NUM_RD-1:0]                rd_resp_vld,
    input  logic [NUM_RD-1:0]                rd_resp_rdy,
    output logic [DATA_W-1:0]                rd_resp_pd,
    input  logic [NUM_RD-1:0]                rd_fifo_pop,
    output logic                             rid_err,
    output logic [ID_WIDTH-1:0]              M_AXI_ARID,
    output logic [ADDR_W-1:0]                M_AXI_ARADDR,
    output logic [LEN_W-1:0]                 M_AXI_ARLEN,
    output logic [2:0]                       M_AXI_ARSIZE,
    output logic [1:0]                       M_AXI_ARBURST,
    output logic                             M_AXI_ARLOCK,
    output logic [3:0]                       M_AXI_ARCACHE,
    output logic [2:0]                       M_AXI_ARPROT,
    output logic [3:0]                       M_AXI_ARQOS,
    output logic                             M_AXI_ARVALID,
    input  logic                             M_AXI_ARREADY,
    input  logic [ID_WIDTH-1:0]              M_AXI_RID,
    input  logic [DATA_W-1:0]                M_AXI_RDATA,
    input  logic [1:0]                       M_AXI_RRESP,
    input  logic                             M_AXI_RLAST,
    input  logic                             M_AXI_RVALID,
    output logic                             M_AXI_RREADY
);

    localparam int CW = $clog2(CREDIT + 1);

    logic [NUM_RD-1:0] eligible;
    logic [NUM_RD-1:0] grant;
    logic              slot_free;
    logic [LEN_W-1:0]  req_len  [NUM_RD];
    logic [ADDR_W-1:0] req_addr [NUM_RD];
    logic [CW-1:0]     credit   [NUM_RD];
    logic [LEN_W-1:0]  sel_len;
    logic [ADDR_W-1:0] sel_addr;
    logic [ID_WIDTH-1:0] sel_id;
    logic              unused_r;

    assign M_AXI_ARSIZE  = axi_size(DATA_W);
    assign M_AXI_ARBURST = AXI_BURST_INCR;
    assign M_AXI_ARLOCK  = 1'b0;
    assign M_AXI_ARCACHE = AXI_CACHE_MOD;
    assign M_AXI_ARPROT  = AXI_PROT_DFLT;
    assign M_AXI_ARQOS   = AXI_QOS_DFLT;
    assign unused_r      = ^{M_AXI_RRESP, M_AXI_RLAST};

    assign slot_free  = !M_AXI_ARVALID || M_AXI_ARREADY;
    assign rd_req_rdy = grant;

    for (genvar i = 0; i < NUM_RD; i++) begin : g_client
        logic [31:0] credit_nxt;

        assign req_addr[i] = rd_req_pd[req_pd_base(i, ADDR_W, LEN_W) +: ADDR_W];
        assign req_len[i]  = rd_req_pd[req_pd_base(i, ADDR_W, LEN_W) + ADDR_W +: LEN_W];
        assign eligible[i] = rd_req_vld[i] && (32'(credit[i]) >= 32'(req_len[i]) + 32'd1);

        // Accept and pop can land together; apply the net change and never exceed the FIFO depth.
        always_comb begin
            credit_nxt = 32'(credit[i]) - (grant[i] ? 32'(req_len[i]) + 32'd1 : 32'd0)
                       + (rd_fifo_pop[i] ? 32'd1 : 32'd0);
            if (credit_nxt > 32'(CREDIT)) begin
                credit_nxt = 32'(CREDIT);
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                credit[i] <= CW'(CREDIT);
            end else begin
                credit[i] <= CW'(credit_nxt);
            end
        end
    end

    mcif_rr_arb #(.N(NUM_RD)) u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (eligible),
        .en    (slot_free),
        .grant (grant)
    );

    always_comb begin
        sel_len  = '0;
        sel_addr = '0;
        sel_id   = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            if (grant[i]) begin
                sel_len  = req_len[i];
                sel_addr = req_addr[i];
                sel_id   = ID_WIDTH'(i);
            end
        end
    end

    // AR register slice: a new accept can replace the beat being handed off, so back-to-back ARs have no bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            M_AXI_ARVALID <= 1'b0;
            M_AXI_ARID    <= '0;
            M_AXI_ARADDR  <= '0;
            M_AXI_ARLEN   <= '0;
        end else if (|grant) begin
            M_AXI_ARVALID <= 1'b1;
            M_AXI_ARID    <= sel_id;
            M_AXI_ARADDR  <= sel_addr;
            M_AXI_ARLEN   <= sel_len;
        end else if (M_AXI_ARREADY) begin
            M_AXI_ARVALID <= 1'b0;
        end
    end

    // An RID with no matching client is acknowledged and the beat is dropped, so the bus never locks up.
    always_comb begin
        rd_resp_vld  = '0;
        M_AXI_RREADY = 1'b1;
        for (int k = 0; k < NUM_RD; k++) begin
            if (M_AXI_RID == ID_WIDTH'(k)) begin
                rd_resp_vld[k] = M_AXI_RVALID;
                M_AXI_RREADY   = rd_resp_rdy[k];
            end
        end
    end

    assign rd_resp_pd = M_AXI_RDATA;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rid_err <= 1'b0;
        end else if (M_AXI_RVALID && (32'(M_AXI_RID) >= 32'(NUM_RD))) begin
            rid_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mcif_rd_nr.sv
// Directed self-checking bench for mcif_rd_nr. It covers arbitration, credits, AR backpressure,
// R demux, a bad RID, and reset mid-operation.
module tb_mcif_rd_nr;

    localparam int NUM_RD   = 5;
    localparam int ID_WIDTH = 3;
    localparam int ADDR_W   = 32;
    localparam int LEN_W    = 8;
    localparam int DATA_W   = 256;
    localparam int CREDIT   = 16;
    localparam int PD_W     = LEN_W + ADDR_W;

    logic                      clk;
    logic                      rst_n;
    logic [NUM_RD-1:0]         rd_req_vld;
    logic [NUM_RD-1:0]         rd_req_rdy;
    logic [NUM_RD*PD_W-1:0]    rd_req_pd;
    logic [NUM_RD-1:0]         rd_resp_vld;
    logic [NUM_RD-1:0]         rd_resp_rdy;
    logic [DATA_W-1:0]         rd_resp_pd;
    logic [NUM_RD-1:0]         rd_fifo_pop;
    logic                      rid_err;
    logic [ID_WIDTH-1:0]       M_AXI_ARID;
    logic [ADDR_W-1:0]         M_AXI_ARADDR;
    logic [LEN_W-1:0]          M_AXI_ARLEN;
    logic [2:0]                M_AXI_ARSIZE;
    logic [1:0]                M_AXI_ARBURST;
    logic                      M_AXI_ARLOCK;
    logic [3:0]                M_AXI_ARCACHE;
    logic [2:0]                M_AXI_ARPROT;
    logic [3:0]                M_AXI_ARQOS;
    logic                      M_AXI_ARVALID;
    logic                      M_AXI_ARREADY;
    logic [ID_WIDTH-1:0]       M_AXI_RID;
    logic [DATA_W-1:0]         M_AXI_RDATA;
    logic [1:0]                M_AXI_RRESP;
    logic                      M_AXI_RLAST;
    logic                      M_AXI_RVALID;
    logic                      M_AXI_RREADY;

    int checks = 0;
    int errors = 0;

    mcif_rd_nr #(
        .NUM_RD(NUM_RD), .ID_WIDTH(ID_WIDTH), .ADDR_W(ADDR_W),
        .LEN_W(LEN_W), .DATA_W(DATA_W), .CREDIT(CREDIT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .rd_req_vld(rd_req_vld), .rd_req_rdy(rd_req_rdy), .rd_req_pd(rd_req_pd),
        .rd_resp_vld(rd_resp_vld), .rd_resp_rdy(rd_resp_rdy), .rd_resp_pd(rd_resp_pd),
        .rd_fifo_pop(rd_fifo_pop), .rid_err(rid_err),
        .M_AXI_ARID(M_AXI_ARID), .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARLEN(M_AXI_ARLEN),
        .M_AXI_ARSIZE(M_AXI_ARSIZE), .M_AXI_ARBURST(M_AXI_ARBURST), .M_AXI_ARLOCK(M_AXI_ARLOCK),
        .M_AXI_ARCACHE(M_AXI_ARCACHE), .M_AXI_ARPROT(M_AXI_ARPROT), .M_AXI_ARQOS(M_AXI_ARQOS),
        .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
        .M_AXI_RID(M_AXI_RID), .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
        .M_AXI_RLAST(M_AXI_RLAST), .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired before end of directed sequence");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int client, input logic [LEN_W-1:0] len,
                                 input logic [ADDR_W-1:0] addr);
        rd_req_pd[client*PD_W +: PD_W] = {len, addr};
        rd_req_vld[client]             = 1'b1;
    endtask

    task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clearInputs();
        rd_req_vld    = '0;
        rd_req_pd     = '0;
        rd_resp_rdy   = '0;
        rd_fifo_pop   = '0;
        M_AXI_ARREADY = 1'b0;
        M_AXI_RID     = '0;
        M_AXI_RDATA   = '0;
        M_AXI_RRESP   = '0;
        M_AXI_RLAST   = 1'b0;
        M_AXI_RVALID  = 1'b0;
    endtask

    task automatic pulseReset();
        clearInputs();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        $display("[TB] start");
        clearInputs();
        rst_n = 1'b0;
        #2;
        checkOutput("rst_arvalid", 256'(M_AXI_ARVALID), 256'(0));
        checkOutput("rst_arid",    256'(M_AXI_ARID),    256'(0));
        checkOutput("rst_araddr",  256'(M_AXI_ARADDR),  256'(0));
        checkOutput("rst_arlen",   256'(M_AXI_ARLEN),   256'(0));
        checkOutput("rst_rid_err", 256'(rid_err),       256'(0));
        checkOutput("const_size",  256'(M_AXI_ARSIZE),  256'(5));
        checkOutput("const_burst", 256'(M_AXI_ARBURST), 256'(1));
        checkOutput("const_cache", 256'(M_AXI_ARCACHE), 256'(2));
        checkOutput("const_misc",  256'({M_AXI_ARLOCK, M_AXI_ARPROT, M_AXI_ARQOS}), 256'(0));
        tick();
        rst_n = 1'b1;
        #1;

        // 1: single request from client 2, four R beats, then credit recovery after pops.
        M_AXI_ARREADY = 1'b1;
        applyStimulus(2, 8'd3, 32'h1000);
        #1;
        checkOutput("t1_rdy", 256'(rd_req_rdy), 256'(5'b00100));
        tick();
        rd_req_vld = '0;
        checkOutput("t1_arvalid", 256'(M_AXI_ARVALID), 256'(1));
        checkOutput("t1_arid",    256'(M_AXI_ARID),    256'(2));
        checkOutput("t1_arlen",   256'(M_AXI_ARLEN),   256'(3));
        checkOutput("t1_araddr",  256'(M_AXI_ARADDR),  256'(32'h1000));
        tick();
        checkOutput("t1_ar_drain", 256'(M_AXI_ARVALID), 256'(0));
        rd_resp_rdy = '1;
        for (int b = 0; b < 4; b++) begin
            M_AXI_RVALID = 1'b1;
            M_AXI_RID    = 3'd2;
            M_AXI_RDATA  = 256'hA0 + 256'(b);
            M_AXI_RLAST  = (b == 3);
            #1;
            checkOutput("t1_resp_vld", 256'(rd_resp_vld), 256'(5'b00100));
            checkOutput("t1_resp_pd",  256'(rd_resp_pd),  256'hA0 + 256'(b));
            checkOutput("t1_rready",   256'(M_AXI_RREADY), 256'(1));
            tick();
        end
        rd_resp_rdy[2] = 1'b0;
        #1;
        checkOutput("t1_rready_bp", 256'(M_AXI_RREADY), 256'(0));
        M_AXI_RVALID = 1'b0;
        rd_resp_rdy  = '0;
        #1;
        checkOutput("t1_resp_idle", 256'(rd_resp_vld), 256'(0));
        checkOutput("t1_rid_err",   256'(rid_err),     256'(0));
        applyStimulus(2, 8'd12, 32'h0);
        #1;
        checkOutput("t1_credit12_len12", 256'(rd_req_rdy), 256'(0));
        applyStimulus(2, 8'd11, 32'h0);
        #1;
        checkOutput("t1_credit12_len11", 256'(rd_req_rdy), 256'(5'b00100));
        rd_req_vld = '0;
        rd_fifo_pop[2] = 1'b1;
        for (int p = 0; p < 4; p++) tick();
        rd_fifo_pop = '0;
        applyStimulus(2, 8'd15, 32'h0);
        #1;
        checkOutput("t1_credit16", 256'(rd_req_rdy), 256'(5'b00100));
        rd_req_vld = '0;
        applyStimulus(4, 8'd16, 32'h0);
        #1;
        checkOutput("t1_len_over_credit", 256'(rd_req_rdy), 256'(0));
        rd_req_vld = '0;

        // 2: fairness with all five clients requesting single beats.
        pulseReset();
        M_AXI_ARREADY = 1'b1;
        for (int c = 0; c < NUM_RD; c++) applyStimulus(c, 8'd0, 32'h100 * c);
        for (int n = 0; n < 7; n++) begin
            #1;
            checkOutput("t2_rdy", 256'(rd_req_rdy), 256'(5'b1 << (n % NUM_RD)));
            tick();
            checkOutput("t2_arid",    256'(M_AXI_ARID),    256'(n % NUM_RD));
            checkOutput("t2_araddr",  256'(M_AXI_ARADDR),  256'(32'h100 * (n % NUM_RD)));
            checkOutput("t2_arvalid", 256'(M_AXI_ARVALID), 256'(1));
        end
        rd_req_vld = '0;
        tick();

        // 3: client 0 uses all 16 credits, then needs four pops before it can issue again.
        pulseReset();
        M_AXI_ARREADY = 1'b1;
        applyStimulus(0, 8'd3, 32'h5000);
        for (int j = 0; j < 4; j++) begin
            #1;
            checkOutput("t3_rdy_issue", 256'(rd_req_rdy), 256'(1));
            tick();
        end
        #1;
        checkOutput("t3_stall", 256'(rd_req_rdy), 256'(0));
        rd_fifo_pop[0] = 1'b1;
        tick();
        rd_fifo_pop = '0;
        #1;
        checkOutput("t3_one_pop", 256'(rd_req_rdy), 256'(0));
        rd_fifo_pop[0] = 1'b1;
        tick();
        tick();
        tick();
        rd_fifo_pop = '0;
        #1;
        checkOutput("t3_four_pops", 256'(rd_req_rdy), 256'(1));
        tick();
        rd_req_vld = '0;
        checkOutput("t3_arid",  256'(M_AXI_ARID),  256'(0));
        checkOutput("t3_arlen", 256'(M_AXI_ARLEN), 256'(3));
        tick();

        // 4: ARREADY held low for 10 cycles, then released; a pop and an accept land in the same cycle.
        pulseReset();
        applyStimulus(1, 8'd1, 32'h2000);
        #1;
        checkOutput("t4_first_rdy", 256'(rd_req_rdy), 256'(5'b00010));
        tick();
        applyStimulus(1, 8'd0, 32'h3000);
        applyStimulus(3, 8'd2, 32'h4000);
        for (int w = 0; w < 10; w++) begin
            #1;
            checkOutput("t4_hold_valid", 256'(M_AXI_ARVALID), 256'(1));
            checkOutput("t4_hold_addr",  256'(M_AXI_ARADDR),  256'(32'h2000));
            checkOutput("t4_hold_len",   256'(M_AXI_ARLEN),   256'(1));
            checkOutput("t4_hold_rdy",   256'(rd_req_rdy),    256'(0));
            tick();
        end
        M_AXI_ARREADY = 1'b1;
        #1;
        checkOutput("t4_rr_after_bp", 256'(rd_req_rdy), 256'(5'b01000));
        tick();
        checkOutput("t4_arid3",   256'(M_AXI_ARID),   256'(3));
        checkOutput("t4_araddr3", 256'(M_AXI_ARADDR), 256'(32'h4000));
        rd_req_vld[3] = 1'b0;
        #1;
        checkOutput("t4_next_rdy", 256'(rd_req_rdy), 256'(5'b00010));
        rd_fifo_pop[1] = 1'b1;
        tick();
        rd_fifo_pop = '0;
        rd_req_vld  = '0;
        checkOutput("t4_arid1",   256'(M_AXI_ARID),   256'(1));
        checkOutput("t4_araddr1", 256'(M_AXI_ARADDR), 256'(32'h3000));
        tick();
        applyStimulus(1, 8'd14, 32'h0);
        #1;
        checkOutput("t4_credit14_len14", 256'(rd_req_rdy), 256'(0));
        applyStimulus(1, 8'd13, 32'h0);
        #1;
        checkOutput("t4_credit14_len13", 256'(rd_req_rdy), 256'(5'b00010));
        rd_req_vld = '0;

        // 5: an out-of-range RID is dropped and sets a sticky error flag.
        rd_resp_rdy  = '0;
        M_AXI_RVALID = 1'b1;
        M_AXI_RID    = 3'd7;
        #1;
        checkOutput("t5_rready",   256'(M_AXI_RREADY), 256'(1));
        checkOutput("t5_resp_vld", 256'(rd_resp_vld),  256'(0));
        tick();
        M_AXI_RVALID = 1'b0;
        M_AXI_RID    = '0;
        checkOutput("t5_rid_err", 256'(rid_err), 256'(1));
        tick();
        tick();
        checkOutput("t5_rid_err_sticky", 256'(rid_err), 256'(1));

        // 6: an asynchronous reset while an AR is pending and credit has been spent.
        M_AXI_ARREADY = 1'b0;
        applyStimulus(0, 8'd7, 32'h6000);
        tick();
        rd_req_vld = '0;
        checkOutput("t6_pre_valid", 256'(M_AXI_ARVALID), 256'(1));
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t6_arvalid", 256'(M_AXI_ARVALID), 256'(0));
        checkOutput("t6_araddr",  256'(M_AXI_ARADDR),  256'(0));
        checkOutput("t6_arlen",   256'(M_AXI_ARLEN),   256'(0));
        checkOutput("t6_arid",    256'(M_AXI_ARID),    256'(0));
        checkOutput("t6_rid_err", 256'(rid_err),       256'(0));
        tick();
        rst_n = 1'b1;
        #1;
        applyStimulus(0, 8'd15, 32'h0);
        #1;
        checkOutput("t6_credit_restored", 256'(rd_req_rdy), 256'(1));
        rd_req_vld = '0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
